roi_photon_counter: RTL and testbench
=====================================

ROI_PHOTON_COUNTER -- requirements
Module: roi_photon_counter

Interface
REQ-001 SHALL have parameters: COORD_WIDTH, 10, pixel coordinate width.
REQ-002 SHALL have parameters: NX, 4, site columns; NY, 4, site rows.
REQ-003 SHALL have parameters: X0, 16, Y0, 16, first-site top-left pixel (X0 even).
REQ-004 SHALL have parameters: PITCH_LOG2, 4, site pitch = 2^PITCH_LOG2 pixels, both axes.
REQ-005 SHALL have parameters: ROI_SIZE, 4, square window side (even, <= pitch); ACC_WIDTH, 16, per-site accumulator width.
REQ-006 SHALL have ports, in order:
- i_clk_500 in 1: single clock.
- i_rst_n in 1: reset, asynchronous, active-low.
- i_pixel_valid in 1: pixel pair valid.
- i_pixel_data in 16: [7:0] pixel at x, [15:8] pixel at x+1.
- i_pixel_x / i_pixel_y in COORD_WIDTH: pair coordinate, x even.
- i_frame_done in 1: one-cycle end-of-frame pulse.
- i_sync_fval in 1: synchronized frame valid.
- i_threshold in ACC_WIDTH: occupancy threshold.
- o_occupancy out NX*NY: bit k = row*NX + col.
- o_result_valid out 1: one-cycle result strobe.
- o_saturated out 1: any site saturated in the reported frame.
- o_frame_count out 16: reported-frame counter.

Function
REQ-007 SHALL map a pair to site (col,row) when x>=X0, y>=Y0, col=(x-X0)>>PITCH_LOG2 < NX, row=(y-Y0)>>PITCH_LOG2 < NY, both offsets ((x-X0) mod pitch, (y-Y0) mod pitch) < ROI_SIZE; otherwise discard.
REQ-008 SHALL sum both bytes of a mapped pair (9-bit, unsigned) and add it to that site's accumulator.
REQ-009 SHALL pipeline in two stages: stage 1 registers site index, in-window flag, pair sum; stage 2 updates accumulator; pair sampled at edge N is in the accumulator after edge N+2.
REQ-010 SHALL saturate each accumulator at 2^ACC_WIDTH-1 and set a sticky per-frame saturation flag.
REQ-011 SHALL delay i_frame_done by 2 cycles to align with the pipeline; a pair valid on the same edge as i_frame_done SHALL be included in that frame.
REQ-012 SHALL, on the aligned done (edge T+2 for i_frame_done at edge T), compare all sites: bit=1 iff sum >= i_threshold sampled at that edge.
REQ-013 SHALL drive o_occupancy, o_saturated, o_result_valid=1 registered at edge T+3, and increment o_frame_count (wrapping 0xFFFF->0) at the same edge.
REQ-014 SHALL hold o_occupancy, o_saturated, o_frame_count until the next result; o_result_valid high exactly one cycle.
REQ-015 SHALL clear all accumulators and the saturation flag on the result edge (T+3).
REQ-016 SHALL also clear on a rising edge of i_sync_fval (stale/aborted frame); if a stage-2 update coincides with any clear, the target site SHALL load the new pair sum and all others zero.
REQ-017 SHALL ignore a second i_frame_done arriving before the first result issues (done pipeline non-retriggerable; one result per pulse otherwise).
REQ-018 SHALL not back-pressure; every valid pair is processed in one cycle, back-to-back.

Reset
REQ-019 SHALL, while i_rst_n=0, asynchronously clear pipeline registers, accumulators, delayed done, o_occupancy=0, o_result_valid=0, o_saturated=0, o_frame_count=0.
REQ-020 SHALL, on reset mid-frame, discard partial sums; first result after release reflects only post-reset pairs.

Verification
REQ-021 Pairs 0x6464 at x=16,18, y=16..19, threshold 1000, done pulse -> 3 cycles later o_result_valid=1 for one cycle, o_occupancy=0x0001, o_frame_count=1.
REQ-022 Pairs at x=14, x=20, y=20, x=144 (col 8) only -> o_occupancy=0x0000; pair x=66,y=67 of 0x0101 with threshold 2 -> o_occupancy=0x8000.
REQ-023 Site sum exactly equal to i_threshold (e.g. 1600/1600) -> bit set; 1601 -> bit clear.
REQ-024 ACC_WIDTH=12, 32 pairs 0xFFFF into site 0 -> sum held 4095, o_saturated=1; next frame without overflow -> o_saturated=0.
REQ-025 Pair valid same cycle as i_frame_done -> included; rising i_sync_fval after aborted frame (no done) -> next result excludes pre-edge pairs.
REQ-026 Reset asserted mid-frame with partial sums -> all outputs 0 immediately, next frame result unaffected by pre-reset pairs.

Source files
------------

// File: rtl/roi_photon_counter.sv
// roi_photon_counter: per-site photon sums over square ROI windows on a
// regular grid of trap sites, thresholded into an occupancy map each frame.
//
// Ports:
//   i_clk_500       single clock
//   i_rst_n         asynchronous active-low reset
//   i_pixel_valid   pixel pair valid
//   i_pixel_data    [7:0] pixel at x, [15:8] pixel at x+1
//   i_pixel_x/y     pair coordinate (x even)
//   i_frame_done    one-cycle end-of-frame pulse
//   i_sync_fval     synchronized frame valid (rising edge clears sums)
//   i_threshold     occupancy threshold
//   o_occupancy     bit k = row*NX + col, set when site sum >= threshold
//   o_result_valid  one-cycle result strobe
//   o_saturated     any site saturated in the reported frame
//   o_frame_count   reported-frame counter (wraps)
module roi_photon_counter #(
  parameter int COORD_WIDTH = 10,
  parameter int NX          = 4,
  parameter int NY          = 4,
  parameter int X0          = 16,
  parameter int Y0          = 16,
  parameter int PITCH_LOG2  = 4,
  parameter int ROI_SIZE    = 4,
  parameter int ACC_WIDTH   = 16
) (
  input  logic                   i_clk_500,
  input  logic                   i_rst_n,
  input  logic                   i_pixel_valid,
  input  logic [15:0]            i_pixel_data,
  input  logic [COORD_WIDTH-1:0] i_pixel_x,
  input  logic [COORD_WIDTH-1:0] i_pixel_y,
  input  logic                   i_frame_done,
  input  logic                   i_sync_fval,
  input  logic [ACC_WIDTH-1:0]   i_threshold,
  output logic [NX*NY-1:0]       o_occupancy,
  output logic                   o_result_valid,
  output logic                   o_saturated,
  output logic [15:0]            o_frame_count
);

  localparam int NS = NX * NY;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW = COORD_WIDTH;
  localparam int OW = PITCH_LOG2 + 1;

  // ---------------- stage 0: site mapping (combinational)
  logic [CW-1:0] dx;
  logic [CW-1:0] dy;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          x_ok;
  logic          y_ok;
  logic [SW-1:0] site;
  logic [8:0]    pair_sum;

  assign dx  = i_pixel_x - CW'(X0);
  assign dy  = i_pixel_y - CW'(Y0);
  assign col = dx >> PITCH_LOG2;
  assign row = dy >> PITCH_LOG2;

  // Offset compare is one bit wider so ROI_SIZE == pitch still works.
  assign x_ok = (i_pixel_x >= CW'(X0))
             && (col < CW'(NX))
             && ({1'b0, dx[PITCH_LOG2-1:0]} < OW'(ROI_SIZE));
  assign y_ok = (i_pixel_y >= CW'(Y0))
             && (row < CW'(NY))
             && ({1'b0, dy[PITCH_LOG2-1:0]} < OW'(ROI_SIZE));

  assign site = SW'(row * CW'(NX) + col);

  assign pair_sum = {1'b0, i_pixel_data[7:0]}
                  + {1'b0, i_pixel_data[15:8]};

  // ---------------- stage 1 registers
  logic          s1_valid;
  logic [SW-1:0] s1_site;
  logic [8:0]    s1_sum;

  // ---------------- accumulators and frame state
  logic [ACC_WIDTH-1:0] acc [NS];
  logic                 sat_q;
  logic                 fval_q;
  logic                 done_d1;
  logic                 done_d2;
  logic                 done_d3;
  logic [ACC_WIDTH-1:0] thr_q;

  // ---------------- stage 2: saturating add for the addressed site
  logic [ACC_WIDTH-1:0] cur;
  logic [ACC_WIDTH:0]   ext;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] add_val;
  logic [ACC_WIDTH-1:0] load_val;

  always_comb begin
    cur      = acc[s1_site];
    ext      = {1'b0, cur} + (ACC_WIDTH+1)'(s1_sum);
    ovf      = ext[ACC_WIDTH];
    add_val  = ovf ? '1 : ext[ACC_WIDTH-1:0];
    load_val = ACC_WIDTH'(s1_sum);
  end

  // Clears come from the result edge or a fresh frame start.
  logic fval_rise;
  logic clr;
  logic done_take;

  assign fval_rise = i_sync_fval & ~fval_q;
  assign clr       = done_d3 | fval_rise;
  // Done pipeline is non-retriggerable while a pulse is in flight.
  assign done_take = i_frame_done & ~(done_d1 | done_d2);

  // ---------------- threshold compare
  logic [NS-1:0] occ_c;

  always_comb begin
    occ_c = '0;
    for (int k = 0; k < NS; k++) begin
      occ_c[k] = (acc[k] >= thr_q);
    end
  end

  // ---------------- sequential state
  always_ff @(posedge i_clk_500 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid       <= 1'b0;
      s1_site        <= '0;
      s1_sum         <= '0;
      for (int k = 0; k < NS; k++) begin
        acc[k] <= '0;
      end
      sat_q          <= 1'b0;
      fval_q         <= 1'b0;
      done_d1        <= 1'b0;
      done_d2        <= 1'b0;
      done_d3        <= 1'b0;
      thr_q          <= '0;
      o_occupancy    <= '0;
      o_result_valid <= 1'b0;
      o_saturated    <= 1'b0;
      o_frame_count  <= '0;
    end else begin
      s1_valid <= i_pixel_valid & x_ok & y_ok;
      s1_site  <= site;
      s1_sum   <= pair_sum;
      fval_q   <= i_sync_fval;

      done_d1 <= done_take;
      done_d2 <= done_d1;
      done_d3 <= done_d2;

      // Threshold taken on the aligned done edge, compared next cycle.
      if (done_d2) begin
        thr_q <= i_threshold;
      end

      o_result_valid <= done_d3;
      if (done_d3) begin
        o_occupancy   <= occ_c;
        o_saturated   <= sat_q;
        o_frame_count <= o_frame_count + 16'd1;
      end

      // A pair landing on a clear edge starts the new frame's sum.
      for (int k = 0; k < NS; k++) begin
        if (clr) begin
          if (s1_valid && (s1_site == SW'(k))) begin
            acc[k] <= load_val;
          end else begin
            acc[k] <= '0;
          end
        end else if (s1_valid && (s1_site == SW'(k))) begin
          acc[k] <= add_val;
        end
      end

      if (clr) begin
        sat_q <= 1'b0;
      end else if (s1_valid && ovf) begin
        sat_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_roi_photon_counter.sv
// Bench for roi_photon_counter: directed frames plus random frames,
// checked against a per-frame arithmetic model of site sums.
module tb_roi_photon_counter;

  localparam int AW   = 12;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          done = 1'b0;
  logic          fval = 1'b0;
  logic [15:0]   data = '0;
  logic [9:0]    px = '0;
  logic [9:0]    py = '0;
  logic [AW-1:0] thr = '0;
  logic [15:0]   occ;
  logic          rv;
  logic          sat;
  logic [15:0]   fc;

  int n_vec = 0;
  int n_bad = 0;
  int tot [16];
  bit msat;
  int fc_m = 0;

  always #5 clk = ~clk;

  roi_photon_counter #(
    .ACC_WIDTH(AW)
  ) dut (
    .i_clk_500     (clk),
    .i_rst_n       (rst_n),
    .i_pixel_valid (valid),
    .i_pixel_data  (data),
    .i_pixel_x     (px),
    .i_pixel_y     (py),
    .i_frame_done  (done),
    .i_sync_fval   (fval),
    .i_threshold   (thr),
    .o_occupancy   (occ),
    .o_result_valid(rv),
    .o_saturated   (sat),
    .o_frame_count (fc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int site_of(input int x, input int y);
    int dx;
    int dy;
    if (x < 16 || y < 16) return -1;
    dx = x - 16;
    dy = y - 16;
    if (dx / 16 >= 4 || dy / 16 >= 4) return -1;
    if (dx % 16 >= 4 || dy % 16 >= 4) return -1;
    return (dy / 16) * 4 + dx / 16;
  endfunction

  task automatic madd(input int x, input int y, input logic [15:0] d);
    int s;
    int v;
    s = site_of(x, y);
    if (s < 0) return;
    v = tot[s] + int'(d[7:0]) + int'(d[15:8]);
    if (v > AMAX) begin
      v = AMAX;
      msat = 1'b1;
    end
    tot[s] = v;
  endtask

  task automatic mclear();
    for (int k = 0; k < 16; k++) tot[k] = 0;
    msat = 1'b0;
  endtask

  task automatic pair(input int x, input int y, input logic [15:0] d);
    valid = 1'b1;
    px    = 10'(x);
    py    = 10'(y);
    data  = d;
    madd(x, y, d);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic close_frame(input bit wp, input int x, input int y,
                             input logic [15:0] d);
    logic [15:0] eocc;
    if (wp) begin
      valid = 1'b1;
      px    = 10'(x);
      py    = 10'(y);
      data  = d;
      madd(x, y, d);
    end
    done = 1'b1;
    for (int k = 0; k < 16; k++) eocc[k] = (tot[k] >= int'(thr));
    fc_m = (fc_m + 1) & 16'hffff;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        done  = 1'b0;
        valid = 1'b0;
      end
      chk("result_valid", 32'(rv), 32'(i == 4));
    end
    chk("occupancy", 32'(occ), 32'(eocc));
    chk("saturated", 32'(sat), 32'(msat));
    chk("frame_count", 32'(fc), 32'(fc_m));
    @(negedge clk);
    chk("valid_one_cycle", 32'(rv), 32'(0));
    chk("occupancy_held", 32'(occ), 32'(eocc));
    mclear();
  endtask

  initial begin
    int cnt;
    int n;
    int x;
    int y;
    mclear();
    repeat (3) @(negedge clk);
    chk("rst_occupancy", 32'(occ), 32'(0));
    chk("rst_valid", 32'(rv), 32'(0));
    chk("rst_saturated", 32'(sat), 32'(0));
    chk("rst_frame_count", 32'(fc), 32'(0));
    rst_n = 1'b1;
    fval  = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 2x4 window into site 0.
    thr = AW'(1000);
    for (int yy = 16; yy < 20; yy++) begin
      pair(16, yy, 16'h6464);
      pair(18, yy, 16'h6464);
    end
    close_frame(0, 0, 0, '0);

    // Pairs that must be discarded.
    thr = AW'(1);
    pair(14, 16, 16'hffff);
    pair(20, 16, 16'hffff);
    pair(16, 20, 16'hffff);
    pair(144, 16, 16'hffff);
    close_frame(0, 0, 0, '0);

    // Last site.
    thr = AW'(2);
    pair(66, 67, 16'h0101);
    close_frame(0, 0, 0, '0);

    // Threshold boundary.
    thr = AW'(1600);
    for (int i = 0; i < 8; i++) pair(16 + 2 * (i % 2), 16 + i / 2, 16'h6464);
    close_frame(0, 0, 0, '0);
    thr = AW'(1601);
    for (int i = 0; i < 8; i++) pair(16 + 2 * (i % 2), 16 + i / 2, 16'h6464);
    close_frame(0, 0, 0, '0);

    // Saturation, then a clean frame.
    thr = AW'(AMAX);
    for (int i = 0; i < 32; i++) pair(16, 16, 16'hffff);
    close_frame(0, 0, 0, '0);
    thr = AW'(1);
    pair(16, 16, 16'h0101);
    close_frame(0, 0, 0, '0);

    // Pair on the same edge as done.
    thr = AW'(2);
    close_frame(1, 32, 32, 16'h0101);

    // Aborted frame cleared by rising fval.
    thr = AW'(1);
    pair(16, 16, 16'h2020);
    pair(18, 17, 16'h2020);
    repeat (3) @(negedge clk);
    mclear();
    fval = 1'b0;
    @(negedge clk);
    fval = 1'b1;
    repeat (2) @(negedge clk);
    pair(32, 16, 16'h0101);
    close_frame(0, 0, 0, '0);

    // Second done while the first is in flight.
    thr = AW'(1);
    pair(48, 16, 16'h0303);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rv) cnt++;
    end
    fc_m = (fc_m + 1) & 16'hffff;
    chk("retrigger_results", 32'(cnt), 32'(1));
    chk("retrigger_occ", 32'(occ), 32'h0004);
    chk("retrigger_count", 32'(fc), 32'(fc_m));
    mclear();

    // Reset mid-frame.
    pair(16, 16, 16'hffff);
    pair(16, 17, 16'hffff);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_occupancy", 32'(occ), 32'(0));
    chk("midrst_saturated", 32'(sat), 32'(0));
    chk("midrst_frame_count", 32'(fc), 32'(0));
    chk("midrst_valid", 32'(rv), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mclear();
    fc_m = 0;
    @(negedge clk);
    thr = AW'(1);
    pair(32, 16, 16'h0101);
    close_frame(0, 0, 0, '0);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      thr = AW'($urandom_range(0, 1200));
      n   = $urandom_range(10, 60);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          x = 2 * $urandom_range(0, 100);
          y = $urandom_range(0, 200);
        end else begin
          x = 16 + 16 * $urandom_range(0, 3) + 2 * $urandom_range(0, 1);
          y = 16 + 16 * $urandom_range(0, 3) + $urandom_range(0, 3);
        end
        pair(x, y, 16'($urandom));
        if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      close_frame(bit'($urandom_range(0, 1)), 34, 50, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
